chunked_subtractor: RTL

Multi-cycle unsigned/two's-complement subtractor, the inverse companion of the 64-bit adder in the ALU. It computes a - b - b_in over WIDTH bits, CHUNK bits per clock, LSB chunk first, with the borrow chained between chunks. Valid/ready handshakes on both sides let it sit behind the ALU operand mux and ahead of the writeback stage.

---
 rtl/chunked_subtractor.sv | 139 +++++++++++++
 1 files changed

// File: rtl/chunked_subtractor.sv
// Multi-cycle subtractor: diff = a - b - b_in, CHUNK bits per cycle, LSB chunk first.
// Optional signed-overflow output ovf enabled by defining SUB_OVERFLOW_EN.
module chunked_subtractor #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SUB_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             b_out
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] work_a;
    logic [WIDTH-1:0] work_b;
    logic [WIDTH-1:0] work_diff;
    logic             borrow;
    logic [CW-1:0]    chunk_idx;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] d_chunk;
    logic             borrow_next;
    logic [WIDTH-1:0] diff_merged;
    logic             last_chunk;
    int               chunk_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One chunk of the borrow chain; the extra top bit of the difference is the borrow-out.
    always_comb begin
        chunk_base  = int'(chunk_idx) * CHUNK;
        a_chunk     = work_a[chunk_base +: CHUNK];
        b_chunk     = work_b[chunk_base +: CHUNK];
        {borrow_next, d_chunk} = {1'b0, a_chunk} - {1'b0, b_chunk} - (CHUNK + 1)'(borrow);
        diff_merged = work_diff;
        diff_merged[chunk_base +: CHUNK] = d_chunk;
    end

    assign last_chunk = (chunk_idx == CW'(NCHUNK - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            work_a    <= '0;
            work_b    <= '0;
            work_diff <= '0;
            borrow    <= 1'b0;
            chunk_idx <= '0;
            diff      <= '0;
            b_out     <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work_a    <= a;
                        work_b    <= b;
                        work_diff <= '0;
                        borrow    <= b_in;
                        chunk_idx <= '0;
                    end
                end
                BUSY: begin
                    work_diff <= diff_merged;
                    borrow    <= borrow_next;
                    if (last_chunk) begin
                        chunk_idx <= '0;
                        diff      <= diff_merged;
                        b_out     <= borrow_next;
`ifdef SUB_OVERFLOW_EN
                        // Overflow only possible when operand signs differ.
                        ovf       <= (work_a[WIDTH-1] != work_b[WIDTH-1]) &&
                                     (diff_merged[WIDTH-1] != work_a[WIDTH-1]);
`endif
                    end else begin
                        chunk_idx <= chunk_idx + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
